jk_bank_arbiter: RTL
====================

Name: jk_bank_arbiter

Overview:
- Owns a bank of W JK flip-flop bits and shares write access to them among NREQ requesters.
- Each requester issues one JK command (hold/reset/set/toggle) against one bit index.
- A round-robin arbiter grants one command at a time. A 3-state FSM drives the bank's j/k inputs for exactly one clock, then returns a one-cycle ack to the granted requester.
- Sits between control logic and any status/flag register built from JK cells.

Parameters:
- NREQ, 4, number of requesters (>=2).
- W, 8, number of JK bits in the bank.
- IW, 3, bit-index width; must satisfy 2**IW >= W.

Ports:
- clk     input   1         rising-edge clock
- rst     input   1         synchronous, active-high reset
- req     input   NREQ      per-requester command request, level; held until ack
- cmd     input   2*NREQ    requester r's command at [2r+1:2r]; {j,k}: 00 hold, 01 reset, 10 set, 11 toggle
- idx     input   IW*NREQ   requester r's target bit at [IW*r+IW-1:IW*r]
- ack     output  NREQ      one-cycle completion pulse to the granted requester
- err     output  1         pulses with ack when the latched idx >= W
- gnt_id  output  clog2(NREQ)  id of the current/last granted requester
- busy    output  1         high when FSM is not IDLE
- q       output  W         JK bank state

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - q=0, ack=0, err=0, busy=0, gnt_id=0.
  - FSM=IDLE, round-robin pointer ptr=0.
  - Reset mid-command aborts the command: no ack, no q change.
- IDLE:
  - If any req bit is set at an edge, grant the first requester found scanning ptr, ptr+1, … mod NREQ.
  - Latch its cmd, idx and id into internal registers; gnt_id updates to that id; go to APPLY.
  - If no req is set, stay in IDLE.
- APPLY (exactly one cycle):
  - Bank j/k inputs decode the latched cmd for bit idx only; all other bits see j=k=0.
  - At the closing edge, q[idx] follows the JK truth table: 00 keep, 01 0, 10 1, 11 invert. Go to ACK.
- ACK (exactly one cycle):
  - ack[gnt_id]=1; err=1 if the latched idx >= W.
  - At the closing edge: ptr <= (gnt_id+1) mod NREQ, go to IDLE.
- Latency:
  - Request sampled at edge E0; q changes at E1.
  - ack is high between E1 and E2; next arbitration happens at E3.
  - Throughput: one command per 3 cycles.
- Handshake:
  - Requester holds req/cmd/idx stable until it sees ack, then drops req at or before the next edge.
  - cmd/idx are latched at grant, so later changes to them are ignored.
  - Dropping req after grant does not cancel the command; it still completes and acks.
- Out-of-range idx (>= W): q is unchanged, the command completes normally, and err pulses with ack.
- Hold command (00): the full 3-cycle sequence runs, q is unchanged, ack is issued.
- Simultaneous requests: only the grantee proceeds. Other req lines stay pending and are served in round-robin order, so a continuously asserted requester waits at most NREQ-1 commands.
- ack is one-hot or zero; err is never high without an ack bit.
- busy = (FSM != IDLE).

Test Plan:
- Reset: rst=1 for 2 cycles with random req -> q=8'h00, ack=0, busy=0, gnt_id=0. Assert rst during APPLY -> q unchanged, no ack, FSM IDLE.
- Single requester, sequence:
  - req0 set idx=3 -> q=8'h08, ack[0] at cycle 2.
  - Then toggle idx=3 -> q=8'h00.
  - Then toggle idx=0 -> q=8'h01.
  - Then reset idx=0 -> q=8'h00.
  - Then hold idx=5 -> q stays 8'h00, ack still issued.
- Round-robin: all 4 req held high continuously, each issuing set idx=r -> ack order 0,1,2,3,0; q=8'h0F after the first 4 acks; gnt_id follows 0,1,2,3.
- Fairness after skip: ptr=2 (after granting 1), only req0 and req3 high -> req3 granted first, then req0.
- Out of range: W=6, IW=3, req1 set idx=7 -> q unchanged, ack[1] and err both pulse for one cycle.
- Early drop: req2 deasserted the cycle after grant with cmd=toggle idx=4 -> q[4] still inverts and ack[2] still pulses.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// Bank of W JK flip-flops shared by NREQ requesters through a round-robin arbiter.
// Each granted command drives the bank's j/k for one cycle, then acks the requester.
module jk_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IW   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [2*NREQ-1:0]         cmd,
  input  logic [IW*NREQ-1:0]        idx,
  output logic [NREQ-1:0]           ack,
  output logic                      err,
  output logic [$clog2(NREQ)-1:0]   gnt_id,
  output logic                      busy,
  output logic [W-1:0]              q
);

  localparam int GW = $clog2(NREQ);
  localparam logic [IW:0] W_LIM = (IW+1)'(W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_n;
  logic [GW-1:0]  ptr_r;
  logic [1:0]     cmd_r;
  logic [IW-1:0]  idx_r;
  logic           found_s;
  logic [GW-1:0]  pick_s;
  logic [GW-1:0]  cand_s;
  logic [W-1:0]   j_s;
  logic [W-1:0]   k_s;
  logic [W-1:0]   q_n;
  logic [GW-1:0]  ptr_n;

  // Round-robin search starting at ptr_r
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s = GW'((int'(ptr_r) + i) % NREQ);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // FSM next-state
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) state_n = ST_APPLY;
        else         state_n = ST_IDLE;
      end
      ST_APPLY: state_n = ST_ACK;
      ST_ACK:   state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // j/k decode: only the latched bit sees the command, and only during APPLY
  always_comb begin
    j_s = '0;
    k_s = '0;
    for (int b = 0; b < W; b++) begin
      if (state_r == ST_APPLY && {1'b0, idx_r} == b[IW:0]) begin
        j_s[b] = cmd_r[1];
        k_s[b] = cmd_r[0];
      end else begin
        j_s[b] = 1'b0;
        k_s[b] = 1'b0;
      end
    end
  end

  // JK truth table per bit
  always_comb begin
    q_n = q;
    for (int b = 0; b < W; b++) begin
      case ({j_s[b], k_s[b]})
        2'b00:   q_n[b] = q[b];
        2'b01:   q_n[b] = 1'b0;
        2'b10:   q_n[b] = 1'b1;
        2'b11:   q_n[b] = ~q[b];
        default: q_n[b] = q[b];
      endcase
    end
  end

  // Pointer advances past the requester just served
  always_comb begin
    if (gnt_id == GW'(NREQ - 1)) ptr_n = '0;
    else                         ptr_n = gnt_id + GW'(1);
  end

  // State, latched command and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      cmd_r   <= 2'b00;
      idx_r   <= '0;
      gnt_id  <= '0;
      q       <= '0;
      ack     <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_n;
      busy    <= (state_n != ST_IDLE);
      q       <= q_n;
      if (state_r == ST_IDLE && found_s) begin
        gnt_id <= pick_s;
        cmd_r  <= cmd[2*int'(pick_s) +: 2];
        idx_r  <= idx[IW*int'(pick_s) +: IW];
      end else begin
        gnt_id <= gnt_id;
        cmd_r  <= cmd_r;
        idx_r  <= idx_r;
      end
      // ack/err are registered so they are high exactly while the FSM is in ACK
      if (state_r == ST_APPLY) begin
        ack <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_id;
        err <= ({1'b0, idx_r} >= W_LIM);
      end else begin
        ack <= '0;
        err <= 1'b0;
      end
      if (state_r == ST_ACK) ptr_r <= ptr_n;
      else                   ptr_r <= ptr_r;
    end
  end

endmodule
